appr_operand_normalizer: RTL and testbench

- Upstream stage of appr_multiplier. Normalises one unsigned operand for the approximate multiplier.
- Shifts the operand left one bit per clock until its MSB is 1.
- Returns the top KEEP bits as the truncated mantissa and the number of shifts taken; the multiplier uses the count to de-normalise its product.
- Uses a start/done handshake, matching the multiplier's control style. Two instances feed one multiplier.

---
 rtl/appr_pkg.sv | 15 +
 rtl/appr_operand_normalizer_shift_counter.sv | 22 ++
 rtl/appr_operand_normalizer.sv | 113 +++++++++++
 tb/tb_appr_operand_normalizer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/appr_pkg.sv
// Shared definitions for the approximate multiplier datapath: FSM encoding and
// default operand/mantissa/shift-count widths.
package appr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int OPERAND_W   = 16;
  localparam int MANT_W      = 8;
  localparam int SHIFT_CNT_W = 4;

endpackage

// File: rtl/appr_operand_normalizer_shift_counter.sv
// Up-counter with synchronous clear and enable; clear wins over enable.
module shift_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/appr_operand_normalizer.sv
// Normalises one unsigned operand by left-shifting until the MSB is set, then
// reports the top KEEP bits, the shift count and a zero flag.
//
// Handshake: start is sampled only in IDLE; data_in is captured on that same
// edge. done is a one-cycle Moore pulse in DONE and the results stay valid from
// then until the next accepted start. busy is high in SHIFT and DONE, and any
// start seen while busy is dropped.
module appr_operand_normalizer
  import appr_pkg::*;
#(
  parameter int WIDTH = OPERAND_W,
  parameter int KEEP  = MANT_W,
  parameter int CNT_W = SHIFT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [KEEP-1:0]  mant_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             zero_flag,
  output state_t           fsm_state
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shift_reg;
  logic             zero_q;
  logic             accept;
  logic             reg_zero;
  logic             reg_msb;
  logic             do_shift;

  assign accept   = (state_q == IDLE) && start;
  assign reg_zero = (shift_reg == '0);
  assign reg_msb  = shift_reg[WIDTH-1];
  assign do_shift = (state_q == SHIFT) && !reg_zero && !reg_msb;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an unused encoding falls back to IDLE
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? SHIFT : IDLE;
      SHIFT:   state_d = (reg_zero || reg_msb) ? DONE : SHIFT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SHIFT: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (accept) begin
      shift_reg <= data_in;
    end else if (do_shift) begin
      shift_reg <= shift_reg << 1;
    end
  end

  // A zero operand never shifts, so the count is left at its cleared value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (accept) begin
      zero_q <= 1'b0;
    end else if ((state_q == SHIFT) && reg_zero) begin
      zero_q <= 1'b1;
    end
  end

  shift_counter #(
    .CNT_W(CNT_W)
  ) u_shift_counter (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (do_shift),
    .cnt(shift_cnt)
  );

  assign mant_out  = shift_reg[WIDTH-1 -: KEEP];
  assign zero_flag = zero_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_appr_operand_normalizer.sv
// Directed bench for appr_operand_normalizer: a vector table for single
// operations plus hand-written sequences for ignored start, re-arm and reset abort.
module tb_appr_operand_normalizer;
  import appr_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic [7:0]  mant_out;
  logic [3:0]  shift_cnt;
  logic        zero_flag;
  state_t      fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  appr_operand_normalizer #(
    .WIDTH(16),
    .KEEP (8),
    .CNT_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .mant_out (mant_out),
    .shift_cnt(shift_cnt),
    .zero_flag(zero_flag),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  exp_mant;
    logic [3:0]  exp_cnt;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: one-cycle start, then watch until two cycles past done.
  // lat is the negedge index (1 = first after the accepting edge) where done is seen.
  task automatic run_op(input logic [15:0] d, output int lat, output int ndone,
                        output int busy_bad);
    @(negedge clk);
    start   = 1'b1;
    data_in = d;
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'($urandom_range(0, 65535));
    lat      = 0;
    ndone    = 0;
    busy_bad = 0;
    for (int c = 1; c <= 24; c++) begin
      if (done) begin
        ndone++;
        if (lat == 0) lat = c;
      end
      if (lat == 0 || c == lat) begin
        if (!busy) busy_bad++;
      end else if (busy) begin
        busy_bad++;
      end
      if (lat != 0 && c >= lat + 2) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, ndone, busy_bad;
    logic [5:0] pat;

    vecs[0] = '{16'h8000, 8'h80, 4'd0,  1'b0, 2};
    vecs[1] = '{16'h1234, 8'h91, 4'd3,  1'b0, 5};
    vecs[2] = '{16'h0001, 8'h80, 4'd15, 1'b0, 17};
    vecs[3] = '{16'h0000, 8'h00, 4'd0,  1'b1, 2};
    vecs[4] = '{16'hFFFF, 8'hFF, 4'd0,  1'b0, 2};
    vecs[5] = '{16'h7FFF, 8'hFF, 4'd1,  1'b0, 3};
    vecs[6] = '{16'h0100, 8'h80, 4'd7,  1'b0, 9};
    vecs[7] = '{16'h0003, 8'hC0, 4'd14, 1'b0, 16};
    vecs[8] = '{16'h4000, 8'h80, 4'd1,  1'b0, 3};

    rst     = 1'b1;
    start   = 1'b0;
    data_in = 16'h0;
    @(negedge clk);
    @(negedge clk);
    check("reset_mant", 32'(mant_out), 32'h0);
    check("reset_cnt", 32'(shift_cnt), 32'h0);
    check("reset_zero", 32'(zero_flag), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_state", 32'(fsm_state), 32'(IDLE));
    rst = 1'b0;

    // Table-driven single operations
    foreach (vecs[i]) begin
      run_op(vecs[i].data, lat, ndone, busy_bad);
      check($sformatf("lat_%04h", vecs[i].data), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("ndone_%04h", vecs[i].data), 32'(ndone), 32'd1);
      check($sformatf("busy_%04h", vecs[i].data), 32'(busy_bad), 32'd0);
      check($sformatf("mant_%04h", vecs[i].data), 32'(mant_out), 32'(vecs[i].exp_mant));
      check($sformatf("cnt_%04h", vecs[i].data), 32'(shift_cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("zero_%04h", vecs[i].data), 32'(zero_flag), 32'(vecs[i].exp_zero));
    end

    // Start while busy must be ignored
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'h00F3;
    lat   = 0;
    ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat == 0) lat = c;
      end
      start   = (c == 2);
      data_in = (c == 2) ? 16'hFFFF : 16'h0000;
    end
    check("ign_lat", 32'(lat), 32'd10);
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_mant", 32'(mant_out), 32'hF3);
    check("ign_cnt", 32'(shift_cnt), 32'd8);
    check("ign_zero", 32'(zero_flag), 32'd0);

    // Start held high re-arms after a one-cycle IDLE gap
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'h8000;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      pat[c-1] = done;
      if (c == 6) start = 1'b0;
    end
    check("rearm_pattern", 32'(pat), 32'b010010);
    @(negedge clk);
    @(negedge clk);
    check("rearm_idle_busy", 32'(busy), 32'd0);

    // Reset mid-operation aborts without a done
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'h0001;
    ndone   = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
    end
    rst = 1'b1;
    #1;
    check("abort_mant", 32'(mant_out), 32'h0);
    check("abort_cnt", 32'(shift_cnt), 32'h0);
    check("abort_zero", 32'(zero_flag), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_state", 32'(fsm_state), 32'(IDLE));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_ndone", 32'(ndone), 32'd0);

    run_op(16'h4000, lat, ndone, busy_bad);
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_ndone", 32'(ndone), 32'd1);
    check("post_rst_mant", 32'(mant_out), 32'h80);
    check("post_rst_cnt", 32'(shift_cnt), 32'd1);
    check("post_rst_busy", 32'(busy_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
